// File: rtl/fpu_pkg.sv
// Shared FPU definitions.
// Holds the canonical quiet NaN, the square-root iteration count, the
// exponent bias, the iterative-unit state type and the single-precision
// field layout used to pick operands apart.
package fpu_pkg;

  localparam logic [31:0] QNAN       = 32'h7fc00000;
  localparam int unsigned FSQRT_ITER = 25;
  localparam logic [7:0]  BIAS       = 8'd127;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RND
  } fsqrt_state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/fsqrt_iter_special.sv
// Combinational special-operand classifier for the iterative square root.
// Ports:
//   x          in  32  operand, IEEE single
//   is_special out  1  operand needs no iteration
//   res        out 32  packed result for special operands (0 otherwise)
// Denormals are flushed to signed zero before the sign is considered, so a
// negative denormal behaves like -0.
module fsqrt_iter_special
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  output logic        is_special,
  output logic [31:0] res
);

  fp32_t f;
  assign f = x;

  always_comb begin
    is_special = 1'b1;
    res        = QNAN;
    if (f.exp == '0) begin
      res = {f.sign, 31'b0};
    end else if (f.exp == '1) begin
      if (f.frac == '0 && !f.sign) res = 32'h7f800000;
      else                         res = QNAN;
    end else if (f.sign) begin
      res = QNAN;
    end else begin
      is_special = 1'b0;
      res        = '0;
    end
  end

endmodule

// File: rtl/fsqrt_iter.sv
// Multi-cycle IEEE single-precision square root, restoring digit recurrence,
// one root bit per cycle, round to nearest even.
// Ports:
//   clk   in   1  rising-edge clock
//   rst   in   1  synchronous active-high reset
//   start in   1  request, sampled only while idle
//   x     in  32  operand, sampled with start
//   busy  out  1  operation in flight
//   done  out  1  one-cycle pulse, y valid
//   y     out 32  result, held until the next done
module fsqrt_iter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  output logic        busy,
  output logic        done,
  output logic [31:0] y
);

  fsqrt_state_t state;
  logic [4:0]   cnt;
  logic [49:0]  rad;
  logic [26:0]  rem;
  logic [24:0]  q;
  logic [7:0]   eo;
  logic         sp_flag;
  logic [31:0]  sp_res;

  logic         is_special;
  logic [31:0]  special_res;

  fsqrt_iter_special u_special (
    .x          (x),
    .is_special (is_special),
    .res        (special_res)
  );

  // Result exponent: floor((e + 127) / 2) covers both exponent parities.
  logic [8:0] esum;
  assign esum = {1'b0, x[30:23]} + {1'b0, BIAS};

  // Trial subtraction; bit 29 is the borrow (negative trial).
  logic [29:0] trial;
  logic        trial_ok;
  assign trial    = {1'b0, rem, rad[49:48]} - {3'b000, q, 2'b01};
  assign trial_ok = ~trial[29];

  // Rounding: guard is q[0], sticky is a nonzero final remainder.
  logic        inc;
  logic [23:0] frac_r;
  logic [7:0]  exp_r;
  assign inc    = q[0] & ((rem != '0) | q[1]);
  assign frac_r = {1'b0, q[23:1]} + 24'(inc);
  assign exp_r  = eo + 8'(frac_r[23]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rad     <= '0;
      rem     <= '0;
      q       <= '0;
      eo      <= '0;
      sp_flag <= 1'b0;
      sp_res  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      y       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            sp_flag <= is_special;
            sp_res  <= special_res;
            if (is_special) begin
              state <= RND;
            end else begin
              state <= CALC;
              cnt   <= 5'(FSQRT_ITER - 1);
              rem   <= '0;
              q     <= '0;
              eo    <= esum[8:1];
              // Odd biased exponent: mant24 << 25, even: mant24 << 26.
              if (x[23]) rad <= {2'b01, x[22:0], 25'b0};
              else       rad <= {1'b1, x[22:0], 26'b0};
            end
          end
        end
        CALC: begin
          rad <= {rad[47:0], 2'b00};
          q   <= {q[23:0], trial_ok};
          rem <= trial_ok ? trial[26:0] : {rem[24:0], rad[49:48]};
          if (cnt == '0) state <= RND;
          else           cnt   <= cnt - 5'd1;
        end
        RND: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          // A fraction carry leaves frac_r[22:0] zero, so packing is direct.
          y     <= sp_flag ? sp_res : {1'b0, exp_r, frac_r[22:0]};
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsqrt_iter.sv
module tb_fsqrt_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x;
  logic        busy;
  logic        done;
  logic [31:0] y;

  fsqrt_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] yv;
    int unsigned at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: IEEE sqrt evaluated in double precision, then rounded to
  // single with round-to-nearest-even.
  function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [63:0] db;
    real         v;
    real         r;
    logic [7:0]  se;
    logic [22:0] keep;
    logic [28:0] rest;
    logic        rinc;
    logic [23:0] fr;
    s = a[31];
    e = a[30:23];
    f = a[22:0];
    if (e == 8'd0) return {s, 31'b0};
    if (e == 8'hff) return (f == 23'd0 && !s) ? 32'h7f800000 : 32'h7fc00000;
    if (s) return 32'h7fc00000;
    db   = {1'b0, 11'(e) + 11'd896, f, 29'b0};
    v    = $bitstoreal(db);
    r    = $sqrt(v);
    db   = $realtobits(r);
    se   = 8'(db[62:52] - 11'd896);
    keep = db[51:29];
    rest = db[28:0];
    rinc = rest[28] & ((rest[27:0] != 29'd0) | keep[0]);
    fr   = {1'b0, keep} + 24'(rinc);
    if (fr[23]) se = se + 8'd1;
    return {1'b0, se, fr[22:0]};
  endfunction

  function automatic int unsigned lat(input logic [31:0] a);
    if (a[30:23] == 8'd0 || a[30:23] == 8'hff || a[31]) return 2;
    return 27;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("y", y, mon_e.yv);
        check("latency", cyc, mon_e.at);
      end
    end
  end

  task automatic issue_exp(input logic [31:0] v, input logic [31:0] yexp, input int unsigned l);
    @(negedge clk);
    start = 1'b1;
    x     = v;
    sbq.push_back('{yexp, cyc + l});
    @(negedge clk);
    start = 1'b0;
    x     = $urandom;
  endtask

  task automatic issue(input logic [31:0] v);
    issue_exp(v, ref_sqrt(v), lat(v));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      check("done_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int unsigned c0;
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    repeat (3) @(negedge clk);
    check("reset_y", y, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 4.0 with busy profile, an ignored start at cycle 5, and a
    // back-to-back 9.0 issued on the done cycle.
    @(negedge clk);
    start = 1'b1;
    x     = 32'h40800000;
    c0    = cyc;
    sbq.push_back('{32'h40000000, c0 + 27});
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("busy_profile", {31'b0, busy}, (k <= 26) ? 32'd1 : 32'd0);
      if (k == 5) begin
        start = 1'b1;
        x     = 32'h41100000;
      end
      if (k == 27) begin
        start = 1'b1;
        x     = 32'h41100000;
        sbq.push_back('{32'h40400000, cyc + 27});
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Directed values and specials.
    issue_exp(32'h40000000, 32'h3fb504f3, 27);  wait_idle();
    issue_exp(32'h3f800000, 32'h3f800000, 27);  wait_idle();
    issue_exp(32'hbf800000, 32'h7fc00000, 2);   wait_idle();
    issue_exp(32'h80000000, 32'h80000000, 2);   wait_idle();
    issue_exp(32'h7f800000, 32'h7f800000, 2);   wait_idle();
    issue_exp(32'h00000001, 32'h00000000, 2);   wait_idle();
    issue_exp(32'hff800000, 32'h7fc00000, 2);   wait_idle();
    issue_exp(32'h7fc12345, 32'h7fc00000, 2);   wait_idle();

    // Reset mid-operation: nothing may come out afterwards.
    issue(32'h40400000);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_y", y, 32'd0);
    repeat (40) @(negedge clk);

    // start coincident with rst is dropped.
    rst   = 1'b1;
    start = 1'b1;
    x     = 32'h40800000;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", {31'b0, busy}, 32'd0);
    repeat (35) @(negedge clk);

    // Mantissa sweep at two exponent parities.
    for (int ei = 0; ei < 2; ei++) begin
      for (int i = 0; i < 122; i++) begin
        v[31]    = 1'b0;
        v[30:23] = (ei == 0) ? 8'd99 : 8'd160;
        if (i == 0)      v[22:0] = 23'd1;
        else if (i == 1) v[22:0] = 23'h7fffff;
        else             v[22:0] = 23'($urandom_range(1, 32'h7fffff));
        issue(v);
        wait_idle();
      end
    end

    // Random operands with a bias toward special encodings.
    for (int i = 0; i < 150; i++) begin
      v = $urandom;
      case ($urandom_range(0, 7))
        0: v[30:23] = 8'h00;
        1: v[30:23] = 8'hff;
        2: v[31]    = 1'b1;
        default: v[31] = 1'b0;
      endcase
      issue(v);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsqrt_iter.md
# fsqrt_iter

Multi-cycle IEEE-754 single-precision square root for the FPU: the forward-direction counterpart of the combinational `fsqrt_inv` reciprocal-square-root unit. It produces one root bit per cycle using restoring digit recurrence, rounds to nearest-even, and hands the result back through a start/busy/done handshake. It sits beside `fsqrt_inv` in the FPU and is issued by the FPU sequencer; the sequencer stalls on `busy`.

## Interface
- No parameters; iteration count is fixed by the package constant `FSQRT_ITER` = 25.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only while idle.
- `x` in 32: operand in IEEE single format; sampled with `start`.
- `busy` out 1: high while an operation is in flight (state != IDLE).
- `done` out 1: one-cycle pulse when `y` is valid.
- `y` out 32: result, registered; holds until the next `done`.

## Operation
- States:
  - IDLE: wait for `start`.
  - CALC: digit recurrence.
  - RND: round and pack.
- IDLE to CALC: `start`=1 with a normal operand. Load the radicand, clear the root and remainder, set the counter to 24.
- IDLE to RND: `start`=1 with a special operand. The packed result is latched into the result register.
- CALC to RND: counter = 0 after the current iteration.
- RND to IDLE: always. `y` is updated and `done`=1.
- Special operands (packed result; no iteration):
  - ±0 in: same signed zero out.
  - Denormal in: flushed, giving signed zero out.
  - +inf in: +inf out.
  - NaN in, or any negative nonzero in (including -inf): QNAN = 32'h7fc00000.
- Normal operand: e = biased exponent, mant24 = {1, m}.
  - Odd e (even unbiased exponent): radicand R = mant24 << 25, 50 bits.
  - Even e: R = mant24 << 26.
  - Result exponent e_out = (e + 127) >> 1 (unsigned floor).
- Recurrence: restoring, 25 iterations, one root bit per iteration, MSB first. Remainder register is 27 bits.
  - Trial value T = {rem, next 2 radicand bits} − {q, 2'b01}.
  - If T ≥ 0: q bit = 1 and rem = T. Otherwise q bit = 0 and rem is restored.
- Root q is 25 bits with q[24] = 1.
  - Fraction = q[23:1].
  - Guard = q[0].
  - Sticky = (final rem != 0).
- Rounding is RNE: increment the fraction if guard & (sticky | q[1]).
  - A fraction carry-out clears the fraction and increments e_out.
- Sign of a normal result is 0.
- `start` while busy is ignored; no queuing.
- `x` is not required to be held after the sampling cycle.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `y` = 32'h0, counter = 0, datapath registers = 0.
- Normal-operand latency: `start` is sampled at edge t.
  - Edges t+1 through t+25 perform the iterations.
  - Edge t+26 rounds.
  - `done` is high in the cycle after edge t+26, i.e. 27 cycles after `start`.
- Special-operand latency: `done` is high 2 cycles after `start`.
- `busy` is high from the cycle after `start` is accepted through the last cycle of RND. It is low in the cycle `done` is high.
- `start` asserted in the same cycle as `done` is accepted: back-to-back throughput of one result per 27 cycles.
- `done` never stays high for two consecutive cycles.
- Reset asserted mid-operation aborts it:
  - Next cycle: IDLE, `busy` = 0, `done` = 0, `y` = 0.
  - No stale `done` is produced.
- `start` coincident with `rst`: reset wins; the request is dropped.

## Structure
- Shared package `fpu_pkg` holds:
  - `QNAN`, `FSQRT_ITER`, and the bias constant 127.
  - The IDLE/CALC/RND state enum type.
  - The field-extraction typedef struct: sign, exp[7:0], frac[22:0].
- One sub-module is natural: `fsqrt_iter_special`. It is a combinational classifier that takes `x` and returns {is_special, packed result}.
- The recurrence step and the rounding are inline in `fsqrt_iter`.

## Test plan
- `x` = 32'h40800000 (4.0): expect `y` = 32'h40000000, `done` exactly 27 cycles after `start`, `busy` high for cycles 1–26.
- `x` = 32'h40000000 (2.0): expect `y` = 32'h3FB504F3. `x` = 32'h3F800000: expect `y` = 32'h3F800000.
- Specials, each with `done` 2 cycles after `start`:
  - 32'hBF800000 gives 32'h7fc00000.
  - 32'h80000000 gives 32'h80000000.
  - 32'h7F800000 gives 32'h7F800000.
  - 32'h00000001 gives 32'h00000000.
- Handshake: a second `start` (x = 9.0) issued at cycle 5 is ignored, and only the 4.0 result is produced. Then `start` on the `done` cycle with 9.0 must yield 32'h40400000 27 cycles later.
- Reset: assert `rst` at cycle 10 of an operation. Expect `busy` = 0, `done` = 0, `y` = 0 on the next cycle, and no `done` afterwards.
- Sweep: mantissas 1 to 2^23−1 at e = 99 and at e = 160. `y` must exactly equal the bits of $shortrealtobits($sqrt(x)), with zero ULP tolerance.
